// File: rtl/ram_initiator.sv
// ram_initiator: turns single READ / WRITE / FILL commands into cycles on a
// single-port RAM that has an asynchronous read path.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake; cmd_ready is high only in IDLE
//   cmd_op                00 READ, 01 WRITE, 10 FILL, 11 reserved (dropped)
//   cmd_address           start address
//   cmd_data              write / fill value
//   cmd_count             FILL word count (0 means no write at all)
//   rsp_valid/rsp_ready   read response handshake
//   rsp_data              read result, held stable until the handshake
//   busy                  high whenever the engine is not in IDLE
//   ram_write_enable      registered RAM write strobe
//   ram_address           registered RAM address
//   ram_data_in           registered RAM write data
//   ram_data_out          RAM read data, sampled one cycle after the address
module ram_initiator #(
  parameter int unsigned addr_bits  = 16,
  parameter int unsigned data_bits  = 8,
  parameter int unsigned count_bits = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [addr_bits-1:0]  cmd_address,
  input  logic [data_bits-1:0]  cmd_data,
  input  logic [count_bits-1:0] cmd_count,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [data_bits-1:0]  rsp_data,
  output logic                  busy,
  output logic                  ram_write_enable,
  output logic [addr_bits-1:0]  ram_address,
  output logic [data_bits-1:0]  ram_data_in,
  input  logic [data_bits-1:0]  ram_data_out
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrite = 3'd1;
  localparam logic [2:0] StRead  = 3'd2;
  localparam logic [2:0] StRsp   = 3'd3;
  localparam logic [2:0] StFill  = 3'd4;

  localparam logic [1:0] OpRead  = 2'b00;
  localparam logic [1:0] OpWrite = 2'b01;
  localparam logic [1:0] OpFill  = 2'b10;

  logic [2:0]            state_q, state_d;
  logic                  we_q, we_d;
  logic [addr_bits-1:0]  addr_q, addr_d;
  logic [data_bits-1:0]  wdata_q, wdata_d;
  logic [count_bits-1:0] count_q, count_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [data_bits-1:0]  rsp_data_q, rsp_data_d;
  logic                  cmd_accept;

  // Ready is masked by reset so nothing can be accepted on a reset edge.
  assign cmd_ready  = (state_q == StIdle) && !reset;
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    count_d     = count_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;

    case (state_q)
      StIdle: begin
        if (cmd_accept) begin
          case (cmd_op)
            OpRead: begin
              addr_d  = cmd_address;
              wdata_d = cmd_data;
              state_d = StRead;
            end
            OpWrite: begin
              addr_d  = cmd_address;
              wdata_d = cmd_data;
              we_d    = 1'b1;
              state_d = StWrite;
            end
            OpFill: begin
              addr_d  = cmd_address;
              wdata_d = cmd_data;
              // A zero-length fill only updates the address/data registers.
              if (cmd_count != '0) begin
                we_d    = 1'b1;
                count_d = cmd_count;
                state_d = StFill;
              end
            end
            default: ; // reserved op: accepted and dropped
          endcase
        end
      end

      StWrite: begin
        we_d    = 1'b0;
        state_d = StIdle;
      end

      StRead: begin
        rsp_data_d  = ram_data_out;
        rsp_valid_d = 1'b1;
        state_d     = StRsp;
      end

      StRsp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end

      StFill: begin
        // count_q is the number of writes still to go, including this cycle.
        if (count_q == count_bits'(1)) begin
          we_d    = 1'b0;
          state_d = StIdle;
        end else begin
          addr_d  = addr_q + addr_bits'(1);
          count_d = count_q - count_bits'(1);
        end
      end

      default: begin
        we_d    = 1'b0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      count_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      count_q     <= count_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign busy             = (state_q != StIdle);
  assign rsp_valid        = rsp_valid_q;
  assign rsp_data         = rsp_data_q;
  assign ram_write_enable = we_q;
  assign ram_address      = addr_q;
  assign ram_data_in      = wdata_q;

endmodule

// File: tb/tb_ram_initiator.sv
// Directed bench for ram_initiator with a behavioural async-read RAM and a
// log of every write cycle the RAM sees.
module tb_ram_initiator;

  logic        clock = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_address;
  logic [7:0]  cmd_data;
  logic [15:0] cmd_count;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        busy;
  logic        ram_write_enable;
  logic [15:0] ram_address;
  logic [7:0]  ram_data_in;
  logic [7:0]  ram_data_out;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  mem [0:65535];
  logic [15:0] wr_addr[$];
  logic [7:0]  wr_data[$];

  always #5 clock = ~clock;

  ram_initiator dut (
    .clock            (clock),
    .reset            (reset),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_op           (cmd_op),
    .cmd_address      (cmd_address),
    .cmd_data         (cmd_data),
    .cmd_count        (cmd_count),
    .rsp_valid        (rsp_valid),
    .rsp_ready        (rsp_ready),
    .rsp_data         (rsp_data),
    .busy             (busy),
    .ram_write_enable (ram_write_enable),
    .ram_address      (ram_address),
    .ram_data_in      (ram_data_in),
    .ram_data_out     (ram_data_out)
  );

  assign ram_data_out = mem[ram_address];

  always @(posedge clock) begin
    if (ram_write_enable) begin
      mem[ram_address] <= ram_data_in;
      wr_addr.push_back(ram_address);
      wr_data.push_back(ram_data_in);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic do_read(input string tag, input logic [15:0] a, input logic [7:0] exp);
    cmd_valid   = 1'b1;
    cmd_op      = 2'b00;
    cmd_address = a;
    tick();
    cmd_valid = 1'b0;
    tick();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check(tag, 32'(rsp_data), 32'(exp));
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_op      = 2'b00;
    cmd_address = '0;
    cmd_data    = '0;
    cmd_count   = '0;
    rsp_ready   = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_we", 32'(ram_write_enable), 32'd0);
    check("rst_addr", 32'(ram_address), 32'd0);
    check("rst_din", 32'(ram_data_in), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", 32'(rsp_data), 32'd0);
    reset = 1'b0;
    tick();
    check("post_rst_ready", 32'(cmd_ready), 32'd1);

    // WRITE 0x1234 <- 0xA5, then READ it back
    clear_log();
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_address = 16'h1234; cmd_data = 8'hA5;
    tick();
    cmd_valid = 1'b0;
    check("wr_we", 32'(ram_write_enable), 32'd1);
    check("wr_addr", 32'(ram_address), 32'h1234);
    check("wr_din", 32'(ram_data_in), 32'hA5);
    check("wr_busy", 32'(busy), 32'd1);
    check("wr_ready_low", 32'(cmd_ready), 32'd0);
    tick();
    check("wr_we_done", 32'(ram_write_enable), 32'd0);
    check("wr_idle", 32'(busy), 32'd0);
    check("wr_count", 32'(wr_addr.size()), 32'd1);

    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_address = 16'h1234;
    tick();
    cmd_valid = 1'b0;
    check("rd_e0_valid", 32'(rsp_valid), 32'd0);
    check("rd_e0_we", 32'(ram_write_enable), 32'd0);
    check("rd_e0_addr", 32'(ram_address), 32'h1234);
    tick();
    check("rd_e1_valid", 32'(rsp_valid), 32'd1);
    check("rd_e1_data", 32'(rsp_data), 32'hA5);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("rd_hs_valid", 32'(rsp_valid), 32'd0);
    check("rd_hs_busy", 32'(busy), 32'd0);

    // READ held for 5 cycles with a competing WRITE offered
    clear_log();
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_address = 16'h1234;
    tick();
    cmd_op = 2'b01; cmd_address = 16'h1234; cmd_data = 8'hFF;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", 32'(rsp_data), 32'hA5);
      check("hold_ready", 32'(cmd_ready), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    check("hold_release", 32'(rsp_valid), 32'd0);
    check("hold_no_write", 32'(wr_addr.size()), 32'd0);

    // FILL across the address wrap
    clear_log();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_address = 16'hFFFE; cmd_data = 8'h3C;
    cmd_count = 16'd4;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      logic [15:0] ea;
      ea = 16'hFFFE + 16'(i);
      check("fill_we", 32'(ram_write_enable), 32'd1);
      check("fill_addr", 32'(ram_address), 32'(ea));
      check("fill_din", 32'(ram_data_in), 32'h3C);
      tick();
    end
    check("fill_we_done", 32'(ram_write_enable), 32'd0);
    check("fill_busy", 32'(busy), 32'd0);
    check("fill_count", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) begin
      check("fill_log0", 32'(wr_addr[0]), 32'hFFFE);
      check("fill_log1", 32'(wr_addr[1]), 32'hFFFF);
      check("fill_log2", 32'(wr_addr[2]), 32'h0000);
      check("fill_log3", 32'(wr_addr[3]), 32'h0001);
    end
    do_read("fill_rd0", 16'hFFFE, 8'h3C);
    do_read("fill_rd1", 16'hFFFF, 8'h3C);
    do_read("fill_rd2", 16'h0000, 8'h3C);
    do_read("fill_rd3", 16'h0001, 8'h3C);

    // FILL N=0 and reserved op: nothing happens, ready stays high
    clear_log();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_address = 16'h0055; cmd_data = 8'h77;
    cmd_count = 16'd0;
    tick();
    check("fill0_ready", 32'(cmd_ready), 32'd1);
    check("fill0_busy", 32'(busy), 32'd0);
    check("fill0_we", 32'(ram_write_enable), 32'd0);
    check("fill0_addr", 32'(ram_address), 32'h0055);
    cmd_op = 2'b11; cmd_address = 16'h9999; cmd_data = 8'h11;
    tick();
    cmd_valid = 1'b0;
    check("resv_ready", 32'(cmd_ready), 32'd1);
    check("resv_busy", 32'(busy), 32'd0);
    check("resv_addr", 32'(ram_address), 32'h0055);
    check("resv_din", 32'(ram_data_in), 32'h77);
    check("resv_no_write", 32'(wr_addr.size()), 32'd0);

    // Back-to-back WRITE stream with cmd_valid held high
    clear_log();
    cmd_valid = 1'b1; cmd_op = 2'b01;
    for (int i = 0; i < 4; i++) begin
      cmd_address = 16'h0200 + 16'(i);
      cmd_data    = 8'h10 + 8'(i);
      check("b2b_ready_hi", 32'(cmd_ready), 32'd1);
      tick();
      check("b2b_ready_lo", 32'(cmd_ready), 32'd0);
      tick();
    end
    cmd_valid = 1'b0;
    check("b2b_count", 32'(wr_addr.size()), 32'd4);
    if (wr_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("b2b_addr", 32'(wr_addr[i]), 32'h200 + 32'(i));
        check("b2b_data", 32'(wr_data[i]), 32'h10 + 32'(i));
      end
    end
    do_read("b2b_rd3", 16'h0203, 8'h13);

    // Reset during FILL N=10 at 0x0100
    clear_log();
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_address = 16'h0100; cmd_data = 8'h5A;
    cmd_count = 16'd10;
    tick();
    cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    check("abort_we", 32'(ram_write_enable), 32'd0);
    check("abort_addr", 32'(ram_address), 32'd0);
    check("abort_din", 32'(ram_data_in), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    check("abort_rsp_data", 32'(rsp_data), 32'd0);
    check("abort_ready", 32'(cmd_ready), 32'd0);
    reset = 1'b0;
    tick();
    tick();
    check("abort_count", 32'(wr_addr.size()), 32'd2);
    if (wr_addr.size() == 2) begin
      check("abort_log0", 32'(wr_addr[0]), 32'h0100);
      check("abort_log1", 32'(wr_addr[1]), 32'h0101);
    end

    // Reset while a read response is pending
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_address = 16'h0203;
    tick();
    cmd_valid = 1'b0;
    tick();
    check("rsp_abort_pre", 32'(rsp_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rsp_abort_valid", 32'(rsp_valid), 32'd0);
    check("rsp_abort_data", 32'(rsp_data), 32'd0);
    tick();
    check("rsp_abort_ready", 32'(cmd_ready), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
